pwm_sequencer: RTL and testbench
================================

# pwm_sequencer

Step sequencer that programs and times the `pwm` block. Holds a small table of PWM profiles, each with a period, duty cycle, burst setting and repeat count. It drives the `pwm` configuration inputs from the active table entry and advances to the next entry when the PWM reports enough completed periods or bursts. It sits between the register/host side and `pwm`, and owns `pwm`'s configuration and enable.

## Interface
Parameters:
- `DEPTH`, 8: number of table entries (2..16).
- `AW`, 3: table address width, equal to clog2(`DEPTH`).

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wrEn`  in  1  table write strobe, one entry per cycle.
- `wrAddr`  in  AW  table entry to write.
- `wrPeriod`  in  16  period field for the entry.
- `wrDuty`  in  8  duty-cycle field for the entry, in percent.
- `wrBurst`  in  2  burst field for the entry: {modeBurst, typeBurst}.
- `wrRepeat`  in  8  number of PWM completions per step; 0 is treated as 1.
- `numSteps`  in  AW+1  number of active entries, 1..DEPTH; sampled at `start`.
- `start`  in  1  begin the sequence at entry 0.
- `stop`  in  1  abort the sequence.
- `pwmDone`  in  1  one-cycle completion pulse from `pwm` (`outRST`).
- `period`  out  16  drives `pwm.period`.
- `dutyCycle`  out  8  drives `pwm.dutyCycle`.
- `modeBurst`  out  1  drives `pwm.modeBurst`.
- `typeBurst`  out  1  drives `pwm.typeBurst`.
- `pwmEn`  out  1  PWM run enable; low holds `pwm` idle and restarts its counter.
- `busy`  out  1  high in LOAD and RUN.
- `stepIdx`  out  AW  index of the active entry.
- `seqDone`  out  1  one-cycle pulse when the sequence ends normally.

## Operation
- Table: DEPTH × 34-bit register array (16+8+2+8 bits).
  - Writable in every state.
  - A write to the active entry takes effect only at that entry's next LOAD.
  - Table contents are not cleared by reset.
- Reset (`rst`=0): state=IDLE; `period`=0, `dutyCycle`=0, `modeBurst`=0, `typeBurst`=0, `pwmEn`=0, `busy`=0, `stepIdx`=0, `seqDone`=0; repeat counter=0.
- IDLE:
  - All configuration outputs are 0 and `pwmEn`=0.
  - `start` with `numSteps` in 1..DEPTH: latch `numSteps`, set `stepIdx`=0, go to LOAD.
  - `start` with `numSteps`=0 or `numSteps`>DEPTH is ignored.
- LOAD (exactly one cycle):
  - Register the entry at `stepIdx` onto the outputs.
  - Load the repeat counter with max(`wrRepeat` field, 1).
  - `pwmEn`=0; `pwmDone` is ignored.
  - Go to RUN.
- RUN:
  - `pwmEn`=1.
  - Each `pwmDone` decrements the counter.
  - A `pwmDone` that brings the counter to 0 ends the step:
    - If `stepIdx` < numSteps−1: increment `stepIdx`, go to LOAD.
    - If it is the last step: handled as in Configuration.
- DONE (one cycle): `seqDone`=1, outputs cleared, `pwmEn`=0, go to IDLE.
- Priority: `stop` > `pwmDone` > `start`.
  - `stop` in any state: next state is IDLE, outputs cleared, no `seqDone`.
  - `start` while `busy` is ignored.
- The repeat counter is 8 bits, so each step lasts 1..255 completions.
- `stepIdx` compares against the latched `numSteps`; changing `numSteps` mid-sequence has no effect.
- Async reset mid-RUN: every output goes to its reset value immediately; the sequence is lost.

## Timing
- `start` sampled at edge N: LOAD during cycle N..N+1; outputs valid and `pwmEn`=1 after edge N+2.
- Final `pwmDone` of a step sampled at edge M: LOAD after M, new configuration plus `pwmEn`=1 after edge M+2.
  - `pwmEn` is low for exactly one cycle between steps.
- Final `pwmDone` of the last step (no loop) at edge M: `seqDone` high for cycle M..M+1; `busy`=0 after edge M+2.
- `stop` at edge N: `pwmEn`=0 and outputs 0 after edge N+1.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- `PWM_SEQ_LOOP_EN` defined:
  - After the last step, `stepIdx` wraps to 0 and the block goes to LOAD.
  - DONE is never entered and `seqDone` stays 0.
  - Only `stop` or reset ends the sequence.
- `PWM_SEQ_LOOP_EN` undefined: after the last step the block goes to DONE as described above.

## Test plan
- Reset: drive `rst`=0 mid-RUN. All outputs go to 0 asynchronously; after release the block is in IDLE with `busy`=0.
- Basic sequence:
  - Program entry0 = (500, 90, 2'b11, 2) and entry1 = (20, 50, 2'b00, 1); `numSteps`=2; pulse `start`.
  - Outputs show 500/90/1/1 for 2 `pwmDone` pulses, then 20/50/0/0 for 1 pulse.
  - `pwmEn` drops for 1 cycle at the switch; `seqDone` pulses once.
- Repeat 0: entry with `wrRepeat`=0 advances after exactly 1 `pwmDone`.
- `stop` mid-step:
  - `stop` on the same cycle as `pwmDone`: block goes to IDLE, no advance, no `seqDone`.
  - `start` while `busy` is ignored.
  - `start` with `numSteps`=0 leaves the block in IDLE.
- Live table write: write the active entry during RUN. Outputs are unchanged until that entry is reloaded.
- Loop (`PWM_SEQ_LOOP_EN`), `numSteps`=3:
  - `stepIdx` runs 0,1,2,0,1, and `seqDone` never pulses.
  - `stop` returns the block to IDLE.

Source files
------------

// File: rtl/pwm_sequencer.sv
// pwm_sequencer: steps through a small table of PWM profiles and drives the
// pwm block's configuration and enable from the active entry. Each entry holds
// a period, a duty cycle, a burst setting and a repeat count.
// Optional feature: define PWM_SEQ_LOOP_EN to wrap from the last step back to
// step 0 forever instead of finishing with a seqDone pulse.
module pwm_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [15:0]   wrPeriod,
  input  logic [7:0]    wrDuty,
  input  logic [1:0]    wrBurst,
  input  logic [7:0]    wrRepeat,
  input  logic [AW:0]   numSteps,
  input  logic          start,
  input  logic          stop,
  input  logic          pwmDone,
  output logic [15:0]   period,
  output logic [7:0]    dutyCycle,
  output logic          modeBurst,
  output logic          typeBurst,
  output logic          pwmEn,
  output logic          busy,
  output logic [AW-1:0] stepIdx,
  output logic          seqDone
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  typedef struct packed {
    logic [15:0] period;
    logic [7:0]  duty;
    logic [1:0]  burst;
    logic [7:0]  rep;
  } entry_t;

  localparam logic [AW:0] DepthL = (AW+1)'(DEPTH);

  entry_t        table_q [DEPTH];
  state_t        state_q, state_d;
  logic [15:0]   period_q;
  logic [7:0]    duty_q;
  logic          modeBurst_q, typeBurst_q;
  logic          pwmEn_q, busy_q, seqDone_q;
  logic [AW-1:0] stepIdx_q;
  logic [AW:0]   numSteps_q;
  logic [7:0]    cnt_q;
  entry_t        loadEnt;
  logic          startOk, stepEnd, lastStep;

  // Profile table; never reset, writable at any time, read only in LOAD.
  always_ff @(posedge clk) begin
    if (wrEn && (int'(wrAddr) < DEPTH)) begin
      table_q[wrAddr] <= {wrPeriod, wrDuty, wrBurst, wrRepeat};
    end
  end

  // Next-state decision; stop overrides everything, pwmDone beats start.
  always_comb begin
    loadEnt  = table_q[stepIdx_q];
    startOk  = start && (numSteps != '0) && (numSteps <= DepthL);
    stepEnd  = pwmDone && (cnt_q == 8'd1);
    lastStep = ({1'b0, stepIdx_q} == (numSteps_q - 1'b1));
    state_d  = state_q;
    case (state_q)
      IDLE: if (startOk) state_d = LOAD;
      LOAD: state_d = RUN;
      RUN: begin
        if (stepEnd) begin
`ifdef PWM_SEQ_LOOP_EN
          state_d = LOAD;
`else
          state_d = lastStep ? DONE : LOAD;
`endif
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (stop) state_d = IDLE;
  end

  // State and registered outputs; pwmEn trails RUN by one cycle so the pwm
  // block sees exactly one idle cycle, carrying the new configuration, per step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      period_q    <= '0;
      duty_q      <= '0;
      modeBurst_q <= 1'b0;
      typeBurst_q <= 1'b0;
      pwmEn_q     <= 1'b0;
      busy_q      <= 1'b0;
      seqDone_q   <= 1'b0;
      stepIdx_q   <= '0;
      numSteps_q  <= '0;
      cnt_q       <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d == LOAD) || (state_d == RUN);
      pwmEn_q   <= (state_q == RUN) && ((state_d == LOAD) || (state_d == RUN));
      seqDone_q <= (state_d == DONE);
      if ((state_d == IDLE) || (state_d == DONE)) begin
        period_q    <= '0;
        duty_q      <= '0;
        modeBurst_q <= 1'b0;
        typeBurst_q <= 1'b0;
        stepIdx_q   <= '0;
        cnt_q       <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            numSteps_q <= numSteps;
            stepIdx_q  <= '0;
          end
          LOAD: begin
            period_q    <= loadEnt.period;
            duty_q      <= loadEnt.duty;
            modeBurst_q <= loadEnt.burst[1];
            typeBurst_q <= loadEnt.burst[0];
            cnt_q       <= (loadEnt.rep == 8'd0) ? 8'd1 : loadEnt.rep;
          end
          RUN: begin
            if (pwmDone) begin
              cnt_q <= cnt_q - 8'd1;
              if (stepEnd) stepIdx_q <= lastStep ? '0 : stepIdx_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign period    = period_q;
  assign dutyCycle = duty_q;
  assign modeBurst = modeBurst_q;
  assign typeBurst = typeBurst_q;
  assign pwmEn     = pwmEn_q;
  assign busy      = busy_q;
  assign stepIdx   = stepIdx_q;
  assign seqDone   = seqDone_q;

endmodule

// File: tb/tb_pwm_sequencer.sv
// tb_pwm_sequencer: table-driven single-step vectors, hand-written corner
// sequences and a randomized run, all watched every cycle by a step/age based
// reference model of the sequencer.
module tb_pwm_sequencer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wrEn = 1'b0;
  logic [AW-1:0] wrAddr = '0;
  logic [15:0]   wrPeriod = '0;
  logic [7:0]    wrDuty = '0;
  logic [1:0]    wrBurst = '0;
  logic [7:0]    wrRepeat = '0;
  logic [AW:0]   numSteps = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          pwmDone = 1'b0;
  logic [15:0]   period;
  logic [7:0]    dutyCycle;
  logic          modeBurst, typeBurst, pwmEn, busy, seqDone;
  logic [AW-1:0] stepIdx;

  int checks = 0;
  int errors = 0;

  pwm_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .wrAddr(wrAddr), .wrPeriod(wrPeriod),
    .wrDuty(wrDuty), .wrBurst(wrBurst), .wrRepeat(wrRepeat), .numSteps(numSteps),
    .start(start), .stop(stop), .pwmDone(pwmDone), .period(period),
    .dutyCycle(dutyCycle), .modeBurst(modeBurst), .typeBurst(typeBurst),
    .pwmEn(pwmEn), .busy(busy), .stepIdx(stepIdx), .seqDone(seqDone)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  // One comparison: counts it, and reports a mismatch with both values.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] packOut();
    return {period, dutyCycle, modeBurst, typeBurst, pwmEn, busy, stepIdx, seqDone};
  endfunction

  // Reference model: tracks the active step, how many completions it still
  // needs, and how many cycles have passed since the step was entered.
  typedef struct packed {
    logic [15:0] p;
    logic [7:0]  d;
    logic [1:0]  b;
    logic [7:0]  r;
  } ent_t;

  ent_t          mTab [DEPTH];
  bit            mActive = 0, mInDone = 0;
  int            mStep = 0, mN = 0, mLeft = 0, mAge = 0;
  logic [15:0]   eP = '0;
  logic [7:0]    eD = '0;
  logic          eM = 0, eT = 0, eEn = 0, eBusy = 0, eS = 0;
  logic [AW-1:0] eIdx = '0;

  // Model update on each rising edge from the inputs the DUT samples there.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mActive = 0; mInDone = 0; mAge = 0; mStep = 0;
      eP = '0; eD = '0; eM = 0; eT = 0; eEn = 0; eBusy = 0; eS = 0; eIdx = '0;
    end else begin
      eS = 0;
      if (stop) begin
        mActive = 0; mInDone = 0;
        eP = '0; eD = '0; eM = 0; eT = 0; eEn = 0; eBusy = 0; eIdx = '0;
      end else if (mInDone) begin
        mInDone = 0;
      end else if (!mActive) begin
        if (start && int'(numSteps) >= 1 && int'(numSteps) <= DEPTH) begin
          mActive = 1; mN = int'(numSteps); mStep = 0; mAge = 0;
          eBusy = 1; eIdx = '0; eEn = 0;
        end
      end else begin
        mAge++;
        if (mAge == 1) begin
          eP = mTab[mStep].p; eD = mTab[mStep].d;
          eM = mTab[mStep].b[1]; eT = mTab[mStep].b[0];
          mLeft = (mTab[mStep].r == 0) ? 1 : int'(mTab[mStep].r);
          eEn = 0;
        end else begin
          eEn = 1;
          if (pwmDone) begin
            mLeft--;
            if (mLeft == 0) begin
              if (mStep < mN - 1) begin
                mStep++; mAge = 0; eIdx = AW'(mStep);
              end else begin
`ifdef PWM_SEQ_LOOP_EN
                mStep = 0; mAge = 0; eIdx = '0;
`else
                mActive = 0; mInDone = 1; eS = 1;
                eP = '0; eD = '0; eM = 0; eT = 0; eEn = 0; eBusy = 0; eIdx = '0;
`endif
              end
            end
          end
        end
      end
      if (wrEn) mTab[wrAddr] = {wrPeriod, wrDuty, wrBurst, wrRepeat};
    end
  end

  // Whole-output comparison against the model on every falling edge.
  bit chkOn = 0;
  always @(negedge clk) begin
    if (chkOn) checkOutput("cycle", packOut(), {eP, eD, eM, eT, eEn, eBusy, eIdx, eS});
  end

  // One cycle of control inputs, driven on the falling edge; clears writes.
  task automatic applyStimulus(input logic s, input logic p, input logic d);
    @(negedge clk);
    start = s; stop = p; pwmDone = d; wrEn = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic writeEntry(input int a, input logic [15:0] p, input logic [7:0] d,
                            input logic [1:0] b, input logic [7:0] r);
    @(negedge clk);
    start = 1'b0; stop = 1'b0; pwmDone = 1'b0;
    wrEn = 1'b1; wrAddr = AW'(a); wrPeriod = p; wrDuty = d; wrBurst = b; wrRepeat = r;
  endtask

  typedef struct {
    logic [15:0] p; logic [7:0] d; logic [1:0] b; logic [7:0] r;
    logic [15:0] expP; logic [7:0] expD; logic expM; logic expT; int expDones;
  } vec_t;

  vec_t vecs [4];
  int   cnt;
  int   seen [$];

  // Directed, table-driven and random phases, then the summary line.
  initial begin
    vecs[0] = '{16'd500,   8'd90,  2'b11, 8'd2, 16'd500,   8'd90,  1'b1, 1'b1, 2};
    vecs[1] = '{16'd20,    8'd50,  2'b00, 8'd1, 16'd20,    8'd50,  1'b0, 1'b0, 1};
    vecs[2] = '{16'd1000,  8'd25,  2'b10, 8'd0, 16'd1000,  8'd25,  1'b1, 1'b0, 1};
    vecs[3] = '{16'd65535, 8'd100, 2'b01, 8'd3, 16'd65535, 8'd100, 1'b0, 1'b1, 3};

    step(2);
    checkOutput("resetState", packOut(), 32'd0);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) writeEntry(i, 16'(100 + i), 8'(10 + i), 2'(i), 8'd1);
    step(1);
    chkOn = 1;

    // Single-step vectors: configuration after start, then completion count.
    for (int v = 0; v < 4; v++) begin
      writeEntry(0, vecs[v].p, vecs[v].d, vecs[v].b, vecs[v].r);
      numSteps = 1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      step(3);
      checkOutput($sformatf("vec%0d.period", v), period, vecs[v].expP);
      checkOutput($sformatf("vec%0d.duty", v), dutyCycle, vecs[v].expD);
      checkOutput($sformatf("vec%0d.burst", v), {modeBurst, typeBurst}, {vecs[v].expM, vecs[v].expT});
      checkOutput($sformatf("vec%0d.enable", v), {pwmEn, busy}, 2'b11);
      for (int k = 0; k < vecs[v].expDones - 1; k++) begin
        applyStimulus(1'b0, 1'b0, 1'b1);
        step(2);
        checkOutput($sformatf("vec%0d.stillBusy", v), busy, 1'b1);
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      step(1);
`ifdef PWM_SEQ_LOOP_EN
      checkOutput($sformatf("vec%0d.loopIdx", v), {busy, stepIdx}, {1'b1, 3'd0});
      applyStimulus(1'b0, 1'b1, 1'b0);
      step(2);
`else
      checkOutput($sformatf("vec%0d.seqDone", v), seqDone, 1'b1);
      step(1);
      checkOutput($sformatf("vec%0d.idle", v), {seqDone, busy, pwmEn}, 3'b000);
`endif
    end

    // Basic two-entry sequence with the one-cycle enable gap at the switch.
    writeEntry(0, 16'd500, 8'd90, 2'b11, 8'd2);
    writeEntry(1, 16'd20, 8'd50, 2'b00, 8'd1);
    numSteps = 2;
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(3);
    checkOutput("basic.step0", {period, dutyCycle, modeBurst, typeBurst}, {16'd500, 8'd90, 2'b11});
    applyStimulus(1'b0, 1'b0, 1'b1); step(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      if (!pwmEn) cnt++;
    end
    checkOutput("basic.enGap", cnt, 1);
    checkOutput("basic.step1", {period, dutyCycle, modeBurst, typeBurst, stepIdx}, {16'd20, 8'd50, 2'b00, 3'd1});
    applyStimulus(1'b0, 1'b0, 1'b1);
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      step(1);
      if (seqDone) cnt++;
    end
`ifndef PWM_SEQ_LOOP_EN
    checkOutput("basic.seqDoneCount", cnt, 1);
`else
    checkOutput("basic.noSeqDone", cnt, 0);
    applyStimulus(1'b0, 1'b1, 1'b0); step(2);
`endif

    // Stop coinciding with pwmDone: back to idle, no advance, no seqDone.
    writeEntry(0, 16'd300, 8'd30, 2'b01, 8'd1);
    numSteps = 2;
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(3);
    applyStimulus(1'b0, 1'b1, 1'b1);
    step(1);
    checkOutput("stop.idle", packOut(), 32'd0);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin step(1); if (seqDone || busy) cnt++; end
    checkOutput("stop.quiet", cnt, 0);

    // Start while busy is ignored and numSteps stays latched at 2.
    writeEntry(0, 16'd40, 8'd5, 2'b00, 8'd1);
    numSteps = 2;
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(3);
    numSteps = 1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(1);
    checkOutput("busyStart.idx", {busy, stepIdx}, {1'b1, 3'd0});
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(4);
    checkOutput("busyStart.latched", {busy, stepIdx, seqDone}, {1'b1, 3'd1, 1'b0});
    applyStimulus(1'b0, 1'b1, 1'b0); step(2);

    // Out-of-range step counts never start a sequence.
    numSteps = 0;
    applyStimulus(1'b1, 1'b0, 1'b0); step(3);
    checkOutput("zeroSteps", busy, 1'b0);
    numSteps = 4'(DEPTH + 1);
    applyStimulus(1'b1, 1'b0, 1'b0); step(3);
    checkOutput("tooManySteps", busy, 1'b0);

    // Writing the active entry has no effect until it is loaded again.
    writeEntry(0, 16'd500, 8'd90, 2'b11, 8'd5);
    numSteps = 1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(3);
    writeEntry(0, 16'd777, 8'd77, 2'b00, 8'd1);
    step(3);
    checkOutput("liveWrite.held", {period, dutyCycle}, {16'd500, 8'd90});
    applyStimulus(1'b0, 1'b1, 1'b0); step(1);
    applyStimulus(1'b1, 1'b0, 1'b0); step(3);
    checkOutput("liveWrite.reloaded", {period, dutyCycle}, {16'd777, 8'd77});

    // Asynchronous reset in the middle of RUN.
    @(negedge clk); #2 rst = 1'b0;
    #1 checkOutput("asyncReset", packOut(), 32'd0);
    @(negedge clk); rst = 1'b1;
    step(1);
    checkOutput("afterReset", {busy, pwmEn}, 2'b00);

`ifdef PWM_SEQ_LOOP_EN
    // Loop mode: step index wraps and seqDone never fires.
    for (int i = 0; i < 3; i++) writeEntry(i, 16'(60 + i), 8'd20, 2'b00, 8'd1);
    numSteps = 3;
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(3);
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      seen.push_back(int'(stepIdx));
      applyStimulus(1'b0, 1'b0, 1'b1);
      for (int j = 0; j < 3; j++) begin step(1); if (seqDone) cnt++; end
    end
    checkOutput("loop.order", {seen[0], seen[1], seen[2], seen[3], seen[4]}, {32'd0, 32'd1, 32'd2, 32'd0, 32'd1});
    checkOutput("loop.noSeqDone", cnt, 0);
    applyStimulus(1'b0, 1'b1, 1'b0); step(1);
    checkOutput("loop.stop", busy, 1'b0);
`endif

    // Randomized traffic, judged by the per-cycle model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      wrEn     = ($urandom_range(0, 3) == 0);
      wrAddr   = AW'($urandom_range(0, DEPTH - 1));
      wrPeriod = 16'($urandom);
      wrDuty   = 8'($urandom_range(0, 100));
      wrBurst  = 2'($urandom);
      wrRepeat = 8'($urandom_range(0, 4));
      numSteps = 4'($urandom_range(0, DEPTH + 1));
      start    = ($urandom_range(0, 7) == 0);
      stop     = ($urandom_range(0, 63) == 0);
      pwmDone  = ($urandom_range(0, 2) == 0);
    end
    step(2);
    chkOn = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
